regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port (we3/wa3/wd3, written on negedge clk) between two requesters:
  - the main pipeline writeback (port A);
  - a long-latency unit such as mult/div or an uncached load return (port B).
- A always wins. B results are buffered in a small FIFO and drained into idle write slots, with starvation protection.
- Pending-write hit flags let decode stall on reads of registers still queued.

---
 rtl/regfile_wr_arbiter_if.sv | 26 ++
 rtl/regfile_wr_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: A/B write requests, decode pending-hit lookups and the registered regfile write port
interface regfile_wr_arbiter_if;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic        stall_req;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  modport master (
    output a_we, a_wa, a_wd, b_valid, b_wa, b_wd, ra1, ra2,
    input  b_ready, stall_req, pend_hit1, pend_hit2, we3, wa3, wd3
  );
  modport slave (
    input  a_we, a_wa, a_wd, b_valid, b_wa, b_wd, ra1, ra2,
    output b_ready, stall_req, pend_hit1, pend_hit2, we3, wa3, wd3
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: A-priority share of the regfile write port with a squashing B FIFO and starvation stall; REGFILE_ARB_STAT_EN adds stat_stall/stat_squash
module regfile_wr_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  regfile_wr_arbiter_if.slave bus
`ifdef REGFILE_ARB_STAT_EN
  ,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_squash
`endif
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
  logic [DEPTH-1:0] valid, kill;
  logic [4:0] fwa [DEPTH];
  logic [31:0] fwd [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [7:0] starve;
  logic src_b, a_req, b_beat, same, enq, hv, pop, issue, h1, h2;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign bus.b_ready = count < CW'(DEPTH);

  always_comb begin
    a_req = bus.a_we && bus.a_wa != 5'd0;
    b_beat = bus.b_valid && bus.b_ready;
    same = b_beat && a_req && bus.b_wa == bus.a_wa;
    enq = b_beat && bus.b_wa != 5'd0 && !same;
    hv = count != '0 && valid[head];
    issue = hv && !a_req;
    pop = count != '0 && (!valid[head] || !a_req);
    for (int i = 0; i < DEPTH; i++) kill[i] = a_req && valid[i] && fwa[i] == bus.a_wa;
  end

  always_comb begin
    h1 = bus.we3 && src_b && bus.wa3 == bus.ra1;
    h2 = bus.we3 && src_b && bus.wa3 == bus.ra2;
    for (int i = 0; i < DEPTH; i++) begin
      h1 = h1 || (valid[i] && fwa[i] == bus.ra1);
      h2 = h2 || (valid[i] && fwa[i] == bus.ra2);
    end
    bus.pend_hit1 = bus.ra1 != 5'd0 && h1;
    bus.pend_hit2 = bus.ra2 != 5'd0 && h2;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fwa[tail] <= bus.b_wa;
      fwd[tail] <= bus.b_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      starve <= '0;
      src_b <= 1'b0;
      bus.stall_req <= 1'b0;
      bus.we3 <= 1'b0;
      bus.wa3 <= '0;
      bus.wd3 <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        valid[i] <= (enq && PW'(i) == tail) ? 1'b1 : valid[i] && !kill[i] && !(pop && PW'(i) == head);
      if (pop) head <= nxt(head);
      if (enq) tail <= nxt(tail);
      count <= count + CW'(enq) - CW'(pop);
      starve <= (hv && !issue) ? (starve >= LIM ? starve : starve + 8'd1) : '0;
      bus.stall_req <= hv && !issue && (bus.stall_req || starve >= LIM);
      bus.we3 <= a_req || issue;
      src_b <= issue;
      if (a_req) begin
        bus.wa3 <= bus.a_wa;
        bus.wd3 <= bus.a_wd;
      end else if (issue) begin
        bus.wa3 <= fwa[head];
        bus.wd3 <= fwd[head];
      end
    end
  end

`ifdef REGFILE_ARB_STAT_EN
  logic [31:0] sq_inc;
  logic [32:0] st_sum, sq_sum;
  always_comb begin
    sq_inc = 32'(same);
    for (int i = 0; i < DEPTH; i++) sq_inc = sq_inc + 32'(kill[i]);
    st_sum = {1'b0, stat_stall} + 33'(bus.stall_req);
    sq_sum = {1'b0, stat_squash} + {1'b0, sq_inc};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall <= '0;
      stat_squash <= '0;
    end else begin
      stat_stall <= st_sum[32] ? '1 : st_sum[31:0];
      stat_squash <= sq_sum[32] ? '1 : sq_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random stimulus against a queue-based model, scoreboard on the regfile write port
module tb_regfile_wr_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_wr_arbiter_if bus();
`ifdef REGFILE_ARB_STAT_EN
  logic [31:0] stat_stall, stat_squash;
`endif
  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef REGFILE_ARB_STAT_EN
    ,
    .stat_stall(stat_stall),
    .stat_squash(stat_squash)
`endif
  );
  typedef struct {logic [4:0] wa; logic [31:0] wd; bit live;} ent_t;
  typedef struct {int cyc; logic [4:0] wa; logic [31:0] wd;} exp_t;
  ent_t mq[$];
  exp_t eq[$];
  exp_t em;
  int total = 0, bad = 0, cyc = 0, mwait = 0;
  bit go = 0, last_acc = 0, mstall = 0, mlastb = 0, saw_stall = 0;
  logic [4:0] mlastwa = '0;
  logic [31:0] msst = '0, mssq = '0;
  logic [31:0] rf_dut [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit mhit(input logic [4:0] ra);
    if (ra == 5'd0) return 0;
    if (mlastb && mlastwa == ra) return 1;
    foreach (mq[i]) if (mq[i].live && mq[i].wa == ra) return 1;
    return 0;
  endfunction

  task automatic model_step();
    bit areq, bbeat, hl, iss, nstall;
    if (rst) begin
      mq.delete();
      mwait = 0;
      mstall = 0;
      mlastb = 0;
      msst = 0;
      mssq = 0;
      return;
    end
    areq = bus.a_we && bus.a_wa != 5'd0;
    bbeat = bus.b_valid && mq.size() < DEPTH;
    hl = mq.size() > 0 && mq[0].live;
    iss = hl && !areq;
    if (mstall) msst++;
    mlastb = 0;
    if (areq) begin
      eq.push_back('{cyc + 1, bus.a_wa, bus.a_wd});
      foreach (mq[i]) if (mq[i].live && mq[i].wa == bus.a_wa) begin
        mq[i].live = 0;
        mssq++;
      end
    end else if (iss) begin
      eq.push_back('{cyc + 1, mq[0].wa, mq[0].wd});
      mlastb = 1;
      mlastwa = mq[0].wa;
    end
    nstall = hl && !iss && (mstall || mwait >= LIMIT);
    mwait = (hl && !iss) ? (mwait >= LIMIT ? LIMIT : mwait + 1) : 0;
    if (mq.size() > 0 && (iss || !hl)) void'(mq.pop_front());
    if (bbeat && bus.b_wa != 5'd0) begin
      if (areq && bus.b_wa == bus.a_wa) mssq++;
      else mq.push_back('{bus.b_wa, bus.b_wd, 1'b1});
    end
    mstall = nstall;
  endtask

  task automatic cycle();
    last_acc = bus.b_valid && bus.b_ready;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic set_in(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit bv, input logic [4:0] bwa, input logic [31:0] bwd);
    bus.a_we = we && !bus.stall_req;
    bus.a_wa = wa;
    bus.a_wd = wd;
    bus.b_valid = bv;
    bus.b_wa = bwa;
    bus.b_wd = bwd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  always @(posedge clk)
    if (!rst) assert (!(bus.stall_req && bus.a_we)) else $error("pipeline drove a_we while stall_req set");

  always @(negedge clk) begin
    if (go) begin
      if (bus.we3) begin
        if (eq.size() == 0) chk("we3_unexpected", bus.we3, 0);
        else begin
          em = eq.pop_front();
          chk("we3_cycle", cyc, em.cyc);
          chk("wa3", bus.wa3, em.wa);
          chk("wd3", bus.wd3, em.wd);
          rf_dut[bus.wa3] = bus.wd3;
        end
      end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
        chk("we3_missing", bus.we3, 1);
        void'(eq.pop_front());
      end
      chk("b_ready", bus.b_ready, mq.size() < DEPTH);
      chk("stall_req", bus.stall_req, mstall);
      chk("pend_hit1", bus.pend_hit1, mhit(bus.ra1));
      chk("pend_hit2", bus.pend_hit2, mhit(bus.ra2));
`ifdef REGFILE_ARB_STAT_EN
      chk("stat_stall", stat_stall, msst);
      chk("stat_squash", stat_squash, mssq);
`endif
    end
  end

  initial begin
    int nb;
    foreach (rf_dut[i]) rf_dut[i] = '0;
    bus.ra1 = 0;
    bus.ra2 = 0;
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1;
    cycle();
    go = 1;
    cycle();
    rst = 0;
    set_in(1, 5, 32'h1234, 0, 0, 0);
    cycle();
    idle(2);
    bus.ra1 = 7;
    set_in(0, 0, 0, 1, 7, 32'hCAFE);
    cycle();
    idle(4);
    nb = 0;
    for (int i = 0; i < 45; i++) begin
      set_in(1, 20, 32'(i), nb < 3, 5'(10 + nb), 32'hB0 + 32'(nb));
      cycle();
      if (last_acc) nb++;
      saw_stall |= bus.stall_req;
    end
    chk("bp_beats_accepted", nb, 3);
    chk("bp_stall_seen", saw_stall, 1);
    idle(8);
    bus.ra1 = 9;
    set_in(1, 1, 32'h11, 1, 9, 32'hDEAD);
    cycle();
    set_in(1, 9, 32'h1, 0, 0, 0);
    cycle();
    idle(4);
    chk("r9_final", rf_dut[9], 32'h1);
    bus.ra2 = 3;
    set_in(1, 3, 32'hAAAA, 1, 3, 32'hBBBB);
    cycle();
    set_in(0, 0, 0, 1, 0, 32'hEEEE);
    cycle();
    idle(4);
    chk("r3_final", rf_dut[3], 32'hAAAA);
    chk("r0_untouched", rf_dut[0], 32'h0);
    set_in(1, 20, 0, 1, 12, 1);
    cycle();
    set_in(1, 21, 0, 1, 13, 2);
    cycle();
    bus.ra1 = 12;
    bus.ra2 = 13;
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1;
    cycle();
    rst = 0;
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      bus.ra1 = 5'($urandom_range(0, 7));
      bus.ra2 = 5'($urandom_range(0, 7));
      set_in($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
      cycle();
    end
    rst = 0;
    idle(30);
    chk("scoreboard_drained", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
